// File: rtl/dca_matrix_row_lsu.sv
// Matrix row load/store unit feeding one operand port of the matrix MAC core.
// Loads strided rows from memory into the MAC, or drains MAC rows back to memory.
module dca_matrix_row_lsu #(
  parameter int BW_ADDR        = 32,
  parameter int BW_ROW         = 128,
  parameter int RSP_FIFO_DEPTH = 4,
  localparam int BW_INST       = 2 + BW_ADDR + 16 + 8
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic               sinst_wvalid,
  input  logic [BW_INST-1:0] sinst_wdata,
  output logic               sinst_wready,
  output logic               sinst_decode_finish,
  output logic               sinst_execute_finish,
  output logic               sinst_busy,
  output logic               sload_tensor_row_wvalid,
  output logic               sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]  sload_tensor_row_wdata,
  input  logic               sload_tensor_row_wready,
  output logic               sstore_tensor_row_rvalid,
  output logic               sstore_tensor_row_rlast,
  input  logic               sstore_tensor_row_rready,
  input  logic [BW_ROW-1:0]  sstore_tensor_row_rdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_write,
  output logic [BW_ADDR-1:0] mem_req_addr,
  output logic [BW_ROW-1:0]  mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [BW_ROW-1:0]  mem_rsp_rdata,
  output logic [2:0]         dbg_state
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = RSP_FIFO_DEPTH[CNT_W:0];
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STORE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         opcode_q, opcode_d;
  logic [15:0]        stride_q, stride_d;
  logic [7:0]         num_row_q, num_row_d;
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic [7:0]         req_cnt_q, req_cnt_d;
  logic [7:0]         pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [BW_ROW-1:0]  fifo_mem_q [RSP_FIFO_DEPTH];
  logic [BW_ROW-1:0]  fifo_mem_d [RSP_FIFO_DEPTH];
  logic               pend_q, pend_d;
  logic [BW_ROW-1:0]  wdata_q, wdata_d;
  logic               wready_q, wready_d;
  logic               busy_q, busy_d;
  logic               dec_fin_q, dec_fin_d;
  logic               exe_fin_q, exe_fin_d;

  logic [7:0]         last_row;
  logic [CNT_W:0]     credit_used;
  logic               inst_fire, req_fire, ld_req_fire, rsp_push, row_pop, st_take;

  // Every channel transfers on the cycle where valid && ready are both high at
  // the clock edge; once raised, a valid holds its payload stable until taken.
  always_comb begin
    last_row    = num_row_q - 8'd1;
    credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};

    sinst_wready         = wready_q;
    sinst_busy           = busy_q;
    sinst_decode_finish  = dec_fin_q;
    sinst_execute_finish = exe_fin_q;
    dbg_state            = state_q;

    sload_tensor_row_wvalid = (state_q == ST_LOAD) && (fifo_cnt_q != '0);
    sload_tensor_row_wlast  = sload_tensor_row_wvalid && (pop_cnt_q == last_row);
    sload_tensor_row_wdata  = fifo_mem_q[rptr_q];

    sstore_tensor_row_rvalid = (state_q == ST_STORE) && !pend_q && (req_cnt_q < num_row_q);
    sstore_tensor_row_rlast  = sstore_tensor_row_rvalid && (req_cnt_q == last_row);

    // Credit covers both reads in flight and rows parked in the buffer.
    mem_req_valid = ((state_q == ST_LOAD) && (req_cnt_q < num_row_q) && (credit_used < DEPTH_C))
                 || ((state_q == ST_STORE) && pend_q);
    mem_req_write = (state_q == ST_STORE);
    mem_req_addr  = addr_q;
    mem_req_wdata = wdata_q;

    inst_fire   = sinst_wvalid && wready_q;
    req_fire    = mem_req_valid && mem_req_ready;
    ld_req_fire = req_fire && (state_q == ST_LOAD);
    rsp_push    = mem_rsp_valid && (out_cnt_q != '0);
    row_pop     = sload_tensor_row_wvalid && sload_tensor_row_wready;
    st_take     = sstore_tensor_row_rvalid && sstore_tensor_row_rready;
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    stride_d   = stride_q;
    num_row_d  = num_row_q;
    addr_d     = addr_q;
    req_cnt_d  = req_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    out_cnt_d  = out_cnt_q + CNT_W'(ld_req_fire) - CNT_W'(rsp_push);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(rsp_push) - CNT_W'(row_pop);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_mem_d = fifo_mem_q;
    pend_d     = pend_q;
    wdata_d    = wdata_q;

    if (req_fire) begin
      addr_d    = addr_q + {{(BW_ADDR-16){1'b0}}, stride_q};
      req_cnt_d = req_cnt_q + 8'd1;
    end
    if (rsp_push) begin
      fifo_mem_d[wptr_q] = mem_rsp_rdata;
      wptr_d             = wptr_q + 1'b1;
    end
    if (row_pop) begin
      rptr_d    = rptr_q + 1'b1;
      pop_cnt_d = pop_cnt_q + 8'd1;
    end
    if (st_take) begin
      wdata_d = sstore_tensor_row_rdata;
      pend_d  = 1'b1;
    end
    if (req_fire && (state_q == ST_STORE)) begin
      pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (inst_fire) begin
          opcode_d  = sinst_wdata[1:0];
          addr_d    = sinst_wdata[BW_ADDR+1:2];
          stride_d  = sinst_wdata[BW_ADDR+17:BW_ADDR+2];
          num_row_d = sinst_wdata[BW_ADDR+25:BW_ADDR+18];
          req_cnt_d = 8'd0;
          pop_cnt_d = 8'd0;
          pend_d    = 1'b0;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if ((opcode_q == OP_LOAD) && (num_row_q != 8'd0)) begin
          state_d = ST_LOAD;
        end else if ((opcode_q == OP_STORE) && (num_row_q != 8'd0)) begin
          state_d = ST_STORE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        if (row_pop && (pop_cnt_q == last_row)) state_d = ST_DONE;
      end
      ST_STORE: begin
        if (req_fire && (req_cnt_q == last_row)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wready_d  = (state_d == ST_IDLE);
    busy_d    = (state_d == ST_DECODE) || (state_d == ST_LOAD) || (state_d == ST_STORE);
    exe_fin_d = (state_d == ST_DONE);
    dec_fin_d = (state_q == ST_DECODE);
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      stride_q   <= '0;
      num_row_q  <= '0;
      addr_q     <= '0;
      req_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      pend_q     <= 1'b0;
      wdata_q    <= '0;
      wready_q   <= 1'b0;
      busy_q     <= 1'b0;
      dec_fin_q  <= 1'b0;
      exe_fin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      stride_q   <= stride_d;
      num_row_q  <= num_row_d;
      addr_q     <= addr_d;
      req_cnt_q  <= req_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_mem_q <= fifo_mem_d;
      pend_q     <= pend_d;
      wdata_q    <= wdata_d;
      wready_q   <= wready_d;
      busy_q     <= busy_d;
      dec_fin_q  <= dec_fin_d;
      exe_fin_q  <= exe_fin_d;
    end
  end

  // A response can only land in a full buffer if the credit accounting broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (rstp)
    !(rsp_push && ({1'b0, fifo_cnt_q} == DEPTH_C) && !row_pop));

endmodule

// File: tb/tb_dca_matrix_row_lsu.sv
// Directed bench for dca_matrix_row_lsu: memory/MAC responders, an expectation
// model built from base + i*stride, and a per-cycle compare process.
module tb_dca_matrix_row_lsu;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rstp;
  logic         sinst_wvalid;
  logic [57:0]  sinst_wdata;
  logic         sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy;
  logic         sload_tensor_row_wvalid, sload_tensor_row_wlast, sload_tensor_row_wready;
  logic [127:0] sload_tensor_row_wdata;
  logic         sstore_tensor_row_rvalid, sstore_tensor_row_rlast, sstore_tensor_row_rready;
  logic [127:0] sstore_tensor_row_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_rdata;
  logic [2:0]   dbg_state;

  dca_matrix_row_lsu #(.BW_ADDR(32), .BW_ROW(128), .RSP_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstp(rstp),
    .sinst_wvalid(sinst_wvalid), .sinst_wdata(sinst_wdata), .sinst_wready(sinst_wready),
    .sinst_decode_finish(sinst_decode_finish), .sinst_execute_finish(sinst_execute_finish),
    .sinst_busy(sinst_busy),
    .sload_tensor_row_wvalid(sload_tensor_row_wvalid), .sload_tensor_row_wlast(sload_tensor_row_wlast),
    .sload_tensor_row_wdata(sload_tensor_row_wdata), .sload_tensor_row_wready(sload_tensor_row_wready),
    .sstore_tensor_row_rvalid(sstore_tensor_row_rvalid), .sstore_tensor_row_rlast(sstore_tensor_row_rlast),
    .sstore_tensor_row_rready(sstore_tensor_row_rready), .sstore_tensor_row_rdata(sstore_tensor_row_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic         exp_wr_q[$];
  logic [127:0] exp_wdata_q[$];
  logic [127:0] exp_row_q[$];
  logic [127:0] resp_q[$];
  logic [31:0]  obs_addr_q[$];
  logic [127:0] obs_row_q[$];
  logic [127:0] obs_wdata_q[$];
  logic [127:0] st_data [8];
  int st_take_cnt = 0, st_base = 0, st_num = 0;
  int reads_fired = 0, rows_popped = 0, dec_cnt = 0, exe_cnt = 0;
  int acc_cyc = 0, first_req_cyc = 0, first_rsp_cyc = 0, first_wv_cyc = 0;
  bit seen_req, seen_rsp, seen_wv;
  bit mon_en = 0, rand_ready = 0, rand_rready = 0;
  int hold_until = 0;
  bit prev_stall = 0, prev_write;
  logic [31:0]  prev_addr;
  logic [127:0] prev_wdata;

  function automatic logic [127:0] mem_fn(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // driver: memory, MAC side
  initial begin
    sload_tensor_row_wready  = 1'b0;
    sstore_tensor_row_rready = 1'b0;
    sstore_tensor_row_rdata  = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready            = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      sload_tensor_row_wready  = (cyc >= hold_until);
      sstore_tensor_row_rready = rand_rready ? 1'($urandom_range(0, 1)) : 1'b1;
      sstore_tensor_row_rdata  = st_data[(st_take_cnt - st_base) % 8];
      if (resp_q.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = resp_q.pop_front();
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
      end
    end
  end

  // compare process: sampled mid-cycle, describes the upcoming clock edge
  initial begin
    logic ew;
    int inflight;
    forever begin
      @(negedge clk);
      #2;
      if (rstp) begin
        reads_fired = 0;
        rows_popped = 0;
        prev_stall  = 0;
      end
      if (mon_en) begin
        if (prev_stall) begin
          chk("req_hold_valid", mem_req_valid, 1'b1);
          chk("req_hold_addr", mem_req_addr, prev_addr);
          chk("req_hold_write", mem_req_write, prev_write);
          chk("req_hold_wdata", mem_req_wdata, prev_wdata);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        prev_write = mem_req_write;
        prev_wdata = mem_req_wdata;

        if (sinst_wvalid && sinst_wready) begin
          acc_cyc = cyc + 1;
          seen_req = 0; seen_rsp = 0; seen_wv = 0;
        end
        if (mem_req_valid && !seen_req) begin first_req_cyc = cyc + 1; seen_req = 1; end
        if (mem_rsp_valid && !seen_rsp) begin first_rsp_cyc = cyc + 1; seen_rsp = 1; end
        if (sload_tensor_row_wvalid && !seen_wv) begin first_wv_cyc = cyc + 1; seen_wv = 1; end

        if (mem_req_valid && mem_req_ready) begin
          obs_addr_q.push_back(mem_req_addr);
          if (mem_req_write) obs_wdata_q.push_back(mem_req_wdata);
          if (exp_q.size() == 0) flag("unexpected_mem_req");
          else begin
            chk("req_addr", mem_req_addr, exp_q.pop_front());
            ew = exp_wr_q.pop_front();
            chk("req_write", mem_req_write, ew);
            if (ew) chk("req_wdata", mem_req_wdata, exp_wdata_q.pop_front());
          end
          if (!mem_req_write) begin
            resp_q.push_back(mem_fn(mem_req_addr));
            reads_fired++;
          end
        end

        if (sload_tensor_row_wvalid && sload_tensor_row_wready) begin
          rows_popped++;
          obs_row_q.push_back(sload_tensor_row_wdata);
          if (exp_row_q.size() == 0) flag("unexpected_load_row");
          else begin
            chk("row_data", sload_tensor_row_wdata, exp_row_q.pop_front());
            chk("row_last", sload_tensor_row_wlast, exp_row_q.size() == 0);
          end
        end

        inflight = reads_fired - rows_popped;
        if (sinst_busy) chk("inflight_within_depth", inflight > DEPTH, 1'b0);

        if (sstore_tensor_row_rvalid && sstore_tensor_row_rready) begin
          if (st_take_cnt - st_base >= st_num) flag("unexpected_store_take");
          else chk("store_rlast", sstore_tensor_row_rlast, (st_take_cnt - st_base) == st_num - 1);
          st_take_cnt++;
        end

        if (sinst_decode_finish) dec_cnt++;
        if (sinst_execute_finish) begin
          exe_cnt++;
          chk("busy_low_at_done", sinst_busy, 1'b0);
        end
      end
    end
  end

  // build expectations for one instruction from the address rule
  task automatic prep(input logic [1:0] op, input logic [31:0] base,
                      input logic [15:0] stride, input logic [7:0] num);
    logic [31:0] a;
    obs_addr_q.delete();
    obs_row_q.delete();
    obs_wdata_q.delete();
    st_base = st_take_cnt;
    st_num  = (op == 2'd2) ? int'(num) : 0;
    for (int i = 0; i < int'(num); i++) begin
      a = base + 32'(i) * {16'h0, stride};
      if (op == 2'd1) begin
        exp_q.push_back(a); exp_wr_q.push_back(1'b0); exp_row_q.push_back(mem_fn(a));
      end else if (op == 2'd2) begin
        exp_q.push_back(a); exp_wr_q.push_back(1'b1); exp_wdata_q.push_back(st_data[i % 8]);
      end
    end
    @(negedge clk);
    sinst_wvalid = 1'b1;
    sinst_wdata  = {num, stride, base, op};
  endtask

  task automatic issue();
    int t = 0;
    while (!sinst_wready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) flag("accept_timeout");
    @(negedge clk);
    sinst_wvalid = 1'b0;
  endtask

  task automatic finish(input int d0, input int e0);
    int t = 0;
    while (exe_cnt == e0 && t < 500) begin @(negedge clk); #3; t++; end
    if (t >= 500) flag("execute_timeout");
    @(negedge clk); #3;
    chk("decode_pulses", dec_cnt - d0, 1);
    chk("execute_pulses", exe_cnt - e0, 1);
    chk("reqs_remaining", exp_q.size(), 0);
    chk("rows_remaining", exp_row_q.size(), 0);
    chk("store_takes", st_take_cnt - st_base, st_num);
  endtask

  task automatic run_inst(input logic [1:0] op, input logic [31:0] base,
                          input logic [15:0] stride, input logic [7:0] num);
    int d0, e0;
    d0 = dec_cnt; e0 = exe_cnt;
    prep(op, base, stride, num);
    issue();
    finish(d0, e0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy,
         sload_tensor_row_wvalid, sload_tensor_row_wlast, sstore_tensor_row_rvalid,
         sstore_tensor_row_rlast, mem_req_valid, mem_req_write}, '0);
    chk({tag, "_ldata"}, sload_tensor_row_wdata, '0);
    chk({tag, "_addr"}, mem_req_addr, '0);
    chk({tag, "_wdata"}, mem_req_wdata, '0);
    chk({tag, "_state"}, dbg_state, 3'd0);
  endtask

  initial begin
    int d0, e0, r0, p0, t;
    for (int i = 0; i < 8; i++) st_data[i] = {4{32'hC0DE_0000 + 32'(i)}};
    rstp = 1'b1;
    sinst_wvalid = 1'b0;
    sinst_wdata  = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rstp = 1'b0;
    mon_en = 1;

    // 1: basic load, latency and literal addresses/data
    run_inst(2'd1, 32'h0000_1000, 16'd16, 8'd4);
    chk("t1_req_count", obs_addr_q.size(), 4);
    if (obs_addr_q.size() == 4) begin
      chk("t1_addr0", obs_addr_q[0], 32'h0000_1000);
      chk("t1_addr1", obs_addr_q[1], 32'h0000_1010);
      chk("t1_addr2", obs_addr_q[2], 32'h0000_1020);
      chk("t1_addr3", obs_addr_q[3], 32'h0000_1030);
    end
    if (obs_row_q.size() > 0)
      chk("t1_row0_literal", obs_row_q[0], 128'h00001000_FFFFEFFF_5A5A4A5A_12346678);
    chk("t1_req_latency", first_req_cyc - acc_cyc, 2);
    chk("t1_wvalid_latency", first_wv_cyc - first_rsp_cyc, 1);

    // 2: MAC stalls, buffer fills to depth and stops requesting
    hold_until = cyc + 24;
    r0 = reads_fired; p0 = rows_popped; d0 = dec_cnt; e0 = exe_cnt;
    prep(2'd1, 32'h0000_3000, 16'd64, 8'd8);
    issue();
    while (cyc < hold_until - 2) @(negedge clk);
    #3;
    chk("t2_reads_while_stalled", reads_fired - r0, 4);
    chk("t2_rows_while_stalled", rows_popped - p0, 0);
    finish(d0, e0);

    // 3: store with address wrap
    run_inst(2'd2, 32'hFFFF_FFF0, 16'd16, 8'd2);
    chk("t3_write_count", obs_addr_q.size(), 2);
    if (obs_addr_q.size() == 2) begin
      chk("t3_addr0", obs_addr_q[0], 32'hFFFF_FFF0);
      chk("t3_addr1", obs_addr_q[1], 32'h0000_0000);
    end
    if (obs_wdata_q.size() == 2)
      chk("t3_wdata1_literal", obs_wdata_q[1], 128'hC0DE0001_C0DE0001_C0DE0001_C0DE0001);

    // 4: random memory/MAC backpressure
    rand_ready = 1; rand_rready = 1;
    run_inst(2'd1, 32'h0000_4000, 16'd32, 8'd6);
    run_inst(2'd2, 32'h0000_8000, 16'h0100, 8'd5);
    run_inst(2'd1, 32'hFFFF_FFE0, 16'd16, 8'd5);
    rand_ready = 0; rand_rready = 0;

    // 5: empty and non-memory instructions
    run_inst(2'd1, 32'h0000_5000, 16'd16, 8'd0);
    chk("t5_zero_rows_no_req", obs_addr_q.size(), 0);
    run_inst(2'd3, 32'h0000_5000, 16'd16, 8'd4);
    chk("t5_op3_no_req", obs_addr_q.size(), 0);
    run_inst(2'd0, 32'h0000_5000, 16'd16, 8'd2);
    chk("t5_op0_no_req", obs_addr_q.size(), 0);

    // 6: reset in the middle of a load
    hold_until = cyc + 1000;
    prep(2'd1, 32'h0000_6000, 16'd16, 8'd8);
    issue();
    t = 0;
    while (reads_fired < 2 && t < 50) begin @(negedge clk); #3; t++; end
    if (t >= 50) flag("t6_reads_timeout");
    @(posedge clk);
    #1;
    mon_en = 0;
    rstp = 1'b1;
    resp_q.delete();
    #1;
    chk_all_zero("midreset");
    exp_q.delete(); exp_wr_q.delete(); exp_wdata_q.delete(); exp_row_q.delete();
    hold_until = 0;
    repeat (2) @(negedge clk);
    resp_q.delete();
    rstp = 1'b0;
    @(negedge clk);
    mon_en = 1;
    run_inst(2'd1, 32'h0000_2000, 16'd4, 8'd3);
    chk("t6_req_count", obs_addr_q.size(), 3);
    if (obs_addr_q.size() == 3) begin
      chk("t6_addr0", obs_addr_q[0], 32'h0000_2000);
      chk("t6_addr2", obs_addr_q[2], 32'h0000_2008);
    end
    chk("t6_rows_delivered", obs_row_q.size(), 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dca_matrix_row_lsu.md
Name: dca_matrix_row_lsu

Overview:
- Matrix load/store unit serving one operand port (ma/mb/mc) of the matrix MAC core, directly upstream of it.
- Accepts one LSU instruction at a time over the sinst handshake.
- Load: fetches strided rows from a simple memory request/response port and streams them to the MAC as tensor rows.
- Store: drains tensor rows from the MAC and writes them back to memory.

Parameters:
BW_ADDR, 32, memory address width
BW_ROW, 128, tensor row width (BW_TENSOR_SCALAR*MATRIX_NUM_COL); one memory beat per row
RSP_FIFO_DEPTH, 4, load response buffer depth (power of 2, >=2)
BW_INST (localparam), 2+BW_ADDR+16+8, instruction width

Ports:
clk  in  1  clock
rstp  in  1  reset
sinst_wvalid  in  1  instruction valid
sinst_wdata  in  BW_INST  [1:0] opcode (1 load, 2 store, 0/3 nop); [BW_ADDR+1:2] base address; next 16 bits byte stride; top 8 bits num_row
sinst_wready  out  1  instruction accepted when valid&ready
sinst_decode_finish  out  1  one-cycle pulse after decode
sinst_execute_finish  out  1  one-cycle pulse at completion
sinst_busy  out  1  instruction in flight
sload_tensor_row_wvalid  out  1  load row valid
sload_tensor_row_wlast  out  1  last row of instruction
sload_tensor_row_wdata  out  BW_ROW  load row data
sload_tensor_row_wready  in  1  MAC accepts row
sstore_tensor_row_rvalid  out  1  LSU requests a store row
sstore_tensor_row_rlast  out  1  last store row
sstore_tensor_row_rready  in  1  MAC presents row
sstore_tensor_row_rdata  in  BW_ROW  store row data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 write, 0 read
mem_req_addr  out  BW_ADDR  row address
mem_req_wdata  out  BW_ROW  write data
mem_rsp_valid  in  1  read response valid; in-order; no backpressure
mem_rsp_rdata  in  BW_ROW  read data

Behaviour:
- One clock; reset is asynchronous and active-high. Port names are clk and rstp.
- Reset: all outputs 0, state IDLE, counters 0, FIFO empty. Asserting rstp mid-operation aborts immediately. Outstanding reads are dropped; responses arriving after reset are ignored by the empty credit state. The bench must not issue responses after reset.
- States: IDLE, DECODE, LOAD, STORE, DONE.
- IDLE: sinst_wready=1. On accept, latch fields, busy=1, go to DECODE.
- DECODE: one cycle; decode_finish pulses on exit.
  - load with num_row>0 -> LOAD; store with num_row>0 -> STORE.
  - otherwise (nop, reserved opcode, num_row=0) -> DONE.
- Address of row i = base + i*stride, computed incrementally and truncated modulo 2^BW_ADDR (wrap-around allowed).
- LOAD:
  - Issue read requests while req_cnt<num_row and (outstanding + fifo_count) < RSP_FIFO_DEPTH.
  - The credit counts the request being issued. It is released when a row is popped to the MAC.
  - mem_req_valid holds with stable addr until ready; addr/valid must not change while stalled.
  - Responses push into the FIFO. Overflow is impossible by construction; an assertion checks it.
  - sload wvalid = FIFO non-empty; wdata = FIFO head.
  - wlast=1 when pop_cnt==num_row-1.
  - Push and pop in the same cycle are both honoured.
  - Pop on wvalid&wready; after the last pop -> DONE.
- STORE:
  - rvalid=1 when no write is pending and rows remain; rlast when row_cnt==num_row-1.
  - On rvalid&rready, capture rdata and the address into the write holding register, drop rvalid, and assert mem_req_valid with write=1.
  - On mem_req_ready, clear pending and increment row_cnt.
  - After the last write accept -> DONE. Writes are posted; there is no response.
  - Minimum 2 cycles per row.
- DONE: execute_finish=1 for one cycle; busy drops in the same cycle; -> IDLE. A new instruction is accepted the next cycle at the earliest.
- busy=1 in DECODE, LOAD and STORE; 0 in IDLE and DONE.
- Latency, load with memory ready and response one cycle later:
  - first request 2 cycles after the accept cycle (accept, DECODE, then request);
  - first wvalid the cycle after the response.

Test Plan:
1. Load: base 0x1000, stride 16, num_row 4; mem ready, 1-cycle response -> requests at 0x1000/0x1010/0x1020/0x1030; 4 rows in order; wlast only on the 4th; decode_finish and execute_finish each pulse once.
2. Load with sload_wready=0 for 20 cycles, num_row 8, depth 4 -> at most 4 reads outstanding/buffered and no further requests; rows released in order after wready=1; no data lost.
3. Store: base 0xFFFFFFF0, stride 16, num_row 2 -> writes to 0xFFFFFFF0 then 0x00000000 (wrap), carrying the captured rdata values; rlast on the 2nd row.
4. mem_req_ready randomly low during load and store -> addr, wdata and write stay stable while valid && !ready; row counts exact.
5. num_row=0 load, and opcode 3 -> DECODE then DONE: decode_finish and execute_finish pulses, no mem_req, no row handshakes.
6. rstp asserted during LOAD with 2 reads outstanding -> all outputs 0 asynchronously; the next instruction after reset executes correctly from empty FIFO state.
